flatten_packer: RTL

//  Collects a serial stream of DATA_WIDTH-bit float feature-map elements from the conv/pool stage.

---
 rtl/flatten_packer.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/flatten_packer.sv
// Serial-to-wide packer: gathers one frame of DATA_WIDTH elements into flat_o for the dense layer.
// Optional FLATTEN_CHW_REORDER_EN: channel-major input is scattered into channels-last slot order.
module flatten_packer #(
    parameter int DEPTH      = 64,
    parameter int H          = 5,
    parameter int W          = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_WIDTH-1:0]        data_i,
    input  logic                         valid_i,
    output logic                         ready_o,
    output logic [DATA_WIDTH*DEPTH*H*W-1:0] flat_o,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic [$clog2(DEPTH*H*W+1)-1:0] count_o
);

    localparam int NUMS = DEPTH * H * W;
    localparam int CNTW = $clog2(NUMS + 1);
    localparam int IW   = (NUMS > 1) ? $clog2(NUMS) : 1;

    typedef enum logic {FILL, FULL} state_t;

    state_t                   state_q, state_d;
    logic [CNTW-1:0]          count_q, count_d;
    logic [IW-1:0]            dest_idx;
    logic [DATA_WIDTH*NUMS-1:0] flat_q;
    logic                     beat;

    assign beat = valid_i && ready_o;

    // State and element counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Next state: fill until the last slot lands, hold until downstream takes the frame
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        unique case (state_q)
            FILL: begin
                if (beat) begin
                    count_d = count_q + CNTW'(1);
                    if (count_q == CNTW'(NUMS - 1)) begin
                        state_d = FULL;
                    end
                end
            end
            FULL: begin
                if (ready_i) begin
                    state_d = FILL;
                    count_d = '0;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // Outputs: never accept while a frame is presented, and never while in reset
    always_comb begin
        ready_o = (state_q == FILL) && !rst;
        valid_o = (state_q == FULL);
    end

`ifdef FLATTEN_CHW_REORDER_EN
    localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int HW = (H > 1) ? $clog2(H) : 1;
    localparam int WW = (W > 1) ? $clog2(W) : 1;

    logic [CW-1:0] c_q, c_d;
    logic [HW-1:0] h_q, h_d;
    logic [WW-1:0] w_q, w_d;

    // Channel/row/column position of the next arriving element
    always_ff @(posedge clk) begin
        if (rst) begin
            c_q <= '0;
            h_q <= '0;
            w_q <= '0;
        end else begin
            c_q <= c_d;
            h_q <= h_d;
            w_q <= w_d;
        end
    end

    // Nested wrap w -> h -> c; cleared again when the frame is handed off
    always_comb begin
        c_d = c_q;
        h_d = h_q;
        w_d = w_q;
        if (state_q == FULL && ready_i) begin
            c_d = '0;
            h_d = '0;
            w_d = '0;
        end else if (beat) begin
            if (w_q == WW'(W - 1)) begin
                w_d = '0;
                if (h_q == HW'(H - 1)) begin
                    h_d = '0;
                    c_d = (c_q == CW'(DEPTH - 1)) ? '0 : c_q + CW'(1);
                end else begin
                    h_d = h_q + HW'(1);
                end
            end else begin
                w_d = w_q + WW'(1);
            end
        end
    end

    assign dest_idx = IW'((int'(h_q) * W + int'(w_q)) * DEPTH + int'(c_q));
`else
    assign dest_idx = count_q[IW-1:0];
`endif

    // Frame buffer: one slot written per beat, otherwise frozen
    always_ff @(posedge clk) begin
        if (rst) begin
            flat_q <= '0;
        end else if (beat) begin
            for (int k = 0; k < NUMS; k++) begin
                if (dest_idx == IW'(k)) begin
                    flat_q[k*DATA_WIDTH +: DATA_WIDTH] <= data_i;
                end
            end
        end
    end

    assign flat_o  = flat_q;
    assign count_o = count_q;

endmodule
